// File: rtl/spi_boot_sequencer.sv
// spi_boot_sequencer
//   Command sequencer behind the SPI slave byte datapath of the bootloader.
//   Decodes 6-byte frames (OUT0..OUT5 qualified by the one-hot OUTSTROBE),
//   runs req/ack memory reads and writes, returns read/status words on
//   SPI_IN and owns the target CPU run line.
//
//   Ports
//     CLK, RST             clock, synchronous active-high reset
//     CS                   SPI chip select, active low; high ends a frame
//     OUT0..OUT5           received frame bytes
//     OUTSTROBE[5:0]       one-cycle pulse, bit n = byte n now valid
//     SPI_IN[31:0]         word shifted out on frame bytes 2..5
//     MEM_REQ/WE/ADDR/WDATA memory request, held until MEM_ACK or timeout
//     MEM_ACK, MEM_RDATA   one-cycle completion pulse and read data
//     CPU_RUN              target CPU run enable
//     BUSY                 high whenever the sequencer is not idle
//
//   Build option: define SPI_BOOT_WPROT_EN to block writes to addresses
//   below PROT_LIM (no request, WPROT flag, error counted).

module spi_boot_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned PROT_LIM = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic [7:0]        OUT0,
  input  logic [7:0]        OUT1,
  input  logic [7:0]        OUT2,
  input  logic [7:0]        OUT3,
  input  logic [7:0]        OUT4,
  input  logic [7:0]        OUT5,
  input  logic [5:0]        OUTSTROBE,
  output logic [31:0]       SPI_IN,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [31:0]       MEM_RDATA,
  output logic              CPU_RUN,
  output logic              BUSY
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

`ifdef SPI_BOOT_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;
  localparam logic [7:0] OP_RUN    = 8'h04;
  localparam logic [7:0] OP_CLEAR  = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] RUN_KEY   = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_ADDR,
    ST_MEM,
    ST_HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             flag_tmo;
  logic             flag_badop;
  logic             flag_wprot;
  logic [7:0]       err_cnt;
  logic [7:0]       last_op;

  logic [ADDR_W-1:0] addr_c;
  logic              wprot_hit_c;
  logic [7:0]        flags_c;
  logic [7:0]        err_inc_c;
  logic              unused_stb;

  // Byte 1 is the address, zero-extended or truncated to ADDR_W.
  assign addr_c      = ADDR_W'(OUT1);
  assign wprot_hit_c = WPROT_ON && (32'(addr_c) < PROT_LIM);
  assign flags_c     = {3'b000, CPU_RUN, flag_wprot, flag_badop, flag_tmo, BUSY};
  // Error counter saturates instead of wrapping.
  assign err_inc_c   = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
  // Bytes 2..4 are only consumed as a group on the byte-5 strobe.
  assign unused_stb  = ^OUTSTROBE[4:2];

  // Frame sequencer: all state, flags and outputs registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      flag_tmo   <= 1'b0;
      flag_badop <= 1'b0;
      flag_wprot <= 1'b0;
      err_cnt    <= '0;
      last_op    <= '0;
      SPI_IN     <= '0;
      MEM_REQ    <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      CPU_RUN    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // CS high wins over a coincident strobe.
          if (!CS && OUTSTROBE[0]) begin
            last_op <= OUT0;
            state   <= ST_OPC;
            BUSY    <= 1'b1;
          end
        end

        ST_OPC: begin
          if (CS) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end else if (OUTSTROBE[1]) begin
            SPI_IN <= '0;
            state  <= ST_HOLD;
            case (last_op)
              OP_READ: begin
                MEM_ADDR <= addr_c;
                MEM_WE   <= 1'b0;
                MEM_REQ  <= 1'b1;
                tmo_cnt  <= '0;
                state    <= ST_MEM;
              end
              OP_WRITE: begin
                if (wprot_hit_c) begin
                  flag_wprot <= 1'b1;
                  err_cnt    <= err_inc_c;
                end else begin
                  MEM_ADDR <= addr_c;
                  state    <= ST_ADDR;
                end
              end
              OP_STATUS: SPI_IN <= {8'hA5, err_cnt, last_op, flags_c};
              OP_RUN: begin
                if (OUT1 == RUN_KEY) begin
                  CPU_RUN <= 1'b1;
                end else begin
                  flag_badop <= 1'b1;
                  err_cnt    <= err_inc_c;
                end
              end
              OP_CLEAR: begin
                flag_tmo   <= 1'b0;
                flag_badop <= 1'b0;
                flag_wprot <= 1'b0;
                err_cnt    <= '0;
              end
              OP_HALT: CPU_RUN <= 1'b0;
              default: begin
                flag_badop <= 1'b1;
                err_cnt    <= err_inc_c;
              end
            endcase
          end
        end

        // Write collects the data word, then requests on the byte-5 strobe.
        ST_ADDR: begin
          if (CS) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end else if (OUTSTROBE[5]) begin
            MEM_WDATA <= {OUT2, OUT3, OUT4, OUT5};
            MEM_WE    <= 1'b1;
            MEM_REQ   <= 1'b1;
            tmo_cnt   <= '0;
            state     <= ST_MEM;
          end
        end

        // Handshake always completes (ack or timeout), even if CS rises.
        ST_MEM: begin
          if (MEM_ACK || (tmo_cnt == CNT_W'(TIMEOUT - 1))) begin
            MEM_REQ <= 1'b0;
            if (!MEM_ACK) begin
              flag_tmo <= 1'b1;
              err_cnt  <= err_inc_c;
            end
            if (!MEM_WE) begin
              SPI_IN <= MEM_ACK ? MEM_RDATA : 32'hDEADDEAD;
            end
            if (CS) begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end else begin
              state <= ST_HOLD;
            end
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        ST_HOLD: begin
          if (CS) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end

        default: begin
          state   <= ST_IDLE;
          MEM_REQ <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_boot_sequencer.sv
// Self-checking bench for spi_boot_sequencer: directed frames followed by
// random frames, each compared against a frame-level reference model.
module tb_spi_boot_sequencer;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned TIMEOUT  = 64;
  localparam int unsigned PROT_LIM = 16;

`ifdef SPI_BOOT_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              CS;
  logic [7:0]        OUT0, OUT1, OUT2, OUT3, OUT4, OUT5;
  logic [5:0]        OUTSTROBE;
  logic [31:0]       SPI_IN;
  logic              MEM_REQ;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [31:0]       MEM_WDATA;
  logic              MEM_ACK;
  logic [31:0]       MEM_RDATA;
  logic              CPU_RUN;
  logic              BUSY;

  spi_boot_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .PROT_LIM(PROT_LIM)) dut (
    .CLK(CLK), .RST(RST), .CS(CS),
    .OUT0(OUT0), .OUT1(OUT1), .OUT2(OUT2), .OUT3(OUT3), .OUT4(OUT4), .OUT5(OUT5),
    .OUTSTROBE(OUTSTROBE), .SPI_IN(SPI_IN),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .CPU_RUN(CPU_RUN), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after ack_delay cycles of MEM_REQ (<=0: never),
  // records each request and watches its fields for stability.
  int          ack_delay    = 0;
  logic [31:0] rd_val       = '0;
  int          req_cnt      = 0;
  int          req_len      = 0;
  int          last_req_len = 0;
  int          stable_err   = 0;
  logic        r_we;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;

  initial begin : responder
    MEM_ACK   = 1'b0;
    MEM_RDATA = '0;
    forever begin
      @(negedge CLK);
      if (MEM_ACK) MEM_ACK = 1'b0;
      if (MEM_REQ) begin
        if (req_len == 0) begin
          req_cnt++;
          r_we    = MEM_WE;
          r_addr  = MEM_ADDR;
          r_wdata = MEM_WDATA;
        end else if (MEM_WE !== r_we || MEM_ADDR !== r_addr ||
                     (r_we && MEM_WDATA !== r_wdata)) begin
          stable_err++;
        end
        req_len++;
        if (req_len == ack_delay) begin
          MEM_ACK   = 1'b1;
          MEM_RDATA = rd_val;
        end
      end else if (req_len != 0) begin
        last_req_len = req_len;
        req_len      = 0;
      end
    end
  end

  // Reference model state (frame level).
  logic [7:0]  m_err, m_last;
  logic        m_tmo, m_badop, m_wprot, m_run;
  logic [31:0] m_spi;
  logic [31:0] pre2_spi;

  function automatic logic [31:0] status_word();
    // BUSY reads 1: the snapshot is taken mid-frame.
    return {8'hA5, m_err, m_last, 3'b000, m_run, m_wprot, m_badop, m_tmo, 1'b1};
  endfunction

  function automatic void bump();
    m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
  endfunction

  task automatic model_reset();
    m_err = '0; m_last = '0; m_tmo = 0; m_badop = 0; m_wprot = 0; m_run = 0; m_spi = '0;
  endtask

  task automatic wait_req_done(input string tag);
    for (int n = 0; n < int'(TIMEOUT) + 8 && MEM_REQ; n++) @(negedge CLK);
    check_val(tag, 32'(MEM_REQ), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] b [6], input int nbytes);
    @(negedge CLK);
    CS = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < nbytes; i++) begin
      case (i)
        0: OUT0 = b[0];
        1: OUT1 = b[1];
        2: OUT2 = b[2];
        3: OUT3 = b[3];
        4: OUT4 = b[4];
        default: OUT5 = b[5];
      endcase
      OUTSTROBE = 6'(1 << i);
      @(negedge CLK);
      OUTSTROBE = '0;
      if (i == 1 && nbytes > 2) begin
        wait_req_done("req_drop_b1");
        pre2_spi = SPI_IN;
      end
      if (i < nbytes - 1) repeat ($urandom_range(2, 0)) @(negedge CLK);
    end
    if (nbytes == 6) wait_req_done("req_drop_b5");
    CS = 1'b1;
    wait_req_done("req_drop_cs");
    for (int n = 0; n < 8 && BUSY; n++) @(negedge CLK);
    check_val("busy_idle", 32'(BUSY), 32'd0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] op, input logic [7:0] adr,
                           input logic [31:0] wd, input int nbytes, input int delay,
                           input logic [31:0] rdata);
    logic [7:0] b [6];
    int         req0;
    bit         exp_req, exp_we, exp_tmo;
    b[0] = op; b[1] = adr;
    b[2] = wd[31:24]; b[3] = wd[23:16]; b[4] = wd[15:8]; b[5] = wd[7:0];
    exp_req = 0; exp_we = 0; exp_tmo = 0;
    if (nbytes >= 1) m_last = op;
    if (nbytes >= 2) begin
      m_spi = (op == 8'h03) ? status_word() : 32'h0;
      case (op)
        8'h01: begin
          if (WPROT_EN && adr < 8'(PROT_LIM)) begin
            m_wprot = 1; bump();
          end else if (nbytes == 6) begin
            exp_req = 1; exp_we = 1;
          end
        end
        8'h02: exp_req = 1;
        8'h03: ;
        8'h04: begin
          if (adr == 8'h5A) m_run = 1;
          else begin m_badop = 1; bump(); end
        end
        8'h06: begin m_err = '0; m_tmo = 0; m_badop = 0; m_wprot = 0; end
        8'h07: m_run = 0;
        default: begin m_badop = 1; bump(); end
      endcase
      if (exp_req) begin
        exp_tmo = (delay < 1 || delay > int'(TIMEOUT));
        if (exp_tmo) begin m_tmo = 1; bump(); end
        if (!exp_we) m_spi = exp_tmo ? 32'hDEADDEAD : rdata;
      end
    end
    ack_delay = delay;
    rd_val    = rdata;
    req0      = req_cnt;
    send_frame(b, nbytes);
    check_val({tag, "_reqn"}, 32'(req_cnt - req0), 32'(exp_req));
    if (exp_req) begin
      check_val({tag, "_we"}, 32'(r_we), 32'(exp_we));
      check_val({tag, "_addr"}, 32'(r_addr), 32'(adr));
      if (exp_we) check_val({tag, "_wdata"}, r_wdata, wd);
      if (exp_tmo) check_val({tag, "_tmolen"}, 32'(last_req_len), TIMEOUT);
      if (!exp_we && nbytes > 2) check_val({tag, "_pre2"}, pre2_spi, m_spi);
    end
    check_val({tag, "_spi"}, SPI_IN, m_spi);
    check_val({tag, "_run"}, 32'(CPU_RUN), 32'(m_run));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got stalled run expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] op, adr;
    int         nb, dl;
    RST = 1'b1; CS = 1'b1; OUTSTROBE = '0;
    OUT0 = '0; OUT1 = '0; OUT2 = '0; OUT3 = '0; OUT4 = '0; OUT5 = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_val("rst_spi", SPI_IN, 32'h0);
    check_val("rst_req", 32'(MEM_REQ), 32'd0);
    check_val("rst_run", 32'(CPU_RUN), 32'd0);
    check_val("rst_busy", 32'(BUSY), 32'd0);
    check_val("rst_we", 32'(MEM_WE), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    run_frame("wr",    8'h01, 8'h10, 32'hDEADBEEF, 6, 3, 32'h0);
    run_frame("rd",    8'h02, 8'h20, 32'h0, 6, 2, 32'h12345678);
    run_frame("rdtmo", 8'h02, 8'h30, 32'h0, 6, 0, 32'h0);
    run_frame("st1",   8'h03, 8'h00, 32'h0, 6, 0, 32'h0);
    run_frame("badop", 8'h09, 8'h00, 32'h0, 6, 0, 32'h0);
    run_frame("st2",   8'h03, 8'h00, 32'h0, 6, 0, 32'h0);
    run_frame("clr",   8'h06, 8'h00, 32'h0, 6, 0, 32'h0);
    run_frame("st3",   8'h03, 8'h00, 32'h0, 6, 0, 32'h0);
    run_frame("run",   8'h04, 8'h5A, 32'h0, 6, 0, 32'h0);
    run_frame("runbad",8'h04, 8'h11, 32'h0, 6, 0, 32'h0);
    run_frame("halt",  8'h07, 8'h00, 32'h0, 6, 0, 32'h0);
    run_frame("wrab",  8'h01, 8'h40, 32'h11223344, 3, 1, 32'h0);
    run_frame("rdab",  8'h02, 8'h50, 32'h0, 2, 5, 32'hCAFEF00D);
    run_frame("wlow",  8'h01, 8'h05, 32'hA5A55A5A, 6, 2, 32'h0);
    run_frame("st4",   8'h03, 8'h00, 32'h0, 6, 0, 32'h0);
    run_frame("run2",  8'h04, 8'h5A, 32'h0, 6, 0, 32'h0);

    // Strobe coinciding with CS high must not start a frame.
    @(negedge CLK);
    OUT0 = 8'h07; OUTSTROBE = 6'b000001;
    @(negedge CLK);
    OUTSTROBE = '0;
    @(negedge CLK);
    check_val("cs_stb_busy", 32'(BUSY), 32'd0);

    // Strobes after decode (HOLD) must be ignored until CS rises.
    CS = 1'b0;
    @(negedge CLK);
    OUT0 = 8'h03; OUTSTROBE = 6'b000001;
    @(negedge CLK);
    OUT1 = 8'h00; OUTSTROBE = 6'b000010;
    @(negedge CLK);
    OUTSTROBE = '0;
    @(negedge CLK);
    OUT0 = 8'h07; OUTSTROBE = 6'b000001;
    @(negedge CLK);
    OUTSTROBE = 6'b000010;
    @(negedge CLK);
    OUTSTROBE = '0; CS = 1'b1;
    repeat (3) @(negedge CLK);
    m_last = 8'h03;
    m_spi  = status_word();
    check_val("hold_run", 32'(CPU_RUN), 32'(m_run));
    check_val("hold_spi", SPI_IN, m_spi);
    check_val("hold_busy", 32'(BUSY), 32'd0);

    // Reset while a read is outstanding.
    ack_delay = 0;
    CS = 1'b0;
    @(negedge CLK);
    OUT0 = 8'h02; OUTSTROBE = 6'b000001;
    @(negedge CLK);
    OUT1 = 8'h60; OUTSTROBE = 6'b000010;
    @(negedge CLK);
    OUTSTROBE = '0;
    repeat (4) @(negedge CLK);
    check_val("rstmem_pre_req", 32'(MEM_REQ), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check_val("rstmem_req", 32'(MEM_REQ), 32'd0);
    check_val("rstmem_run", 32'(CPU_RUN), 32'd0);
    check_val("rstmem_busy", 32'(BUSY), 32'd0);
    check_val("rstmem_spi", SPI_IN, 32'h0);
    RST = 1'b0; CS = 1'b1;
    model_reset();
    repeat (2) @(negedge CLK);
    run_frame("st5", 8'h03, 8'h00, 32'h0, 6, 0, 32'h0);

    // Error counter saturation.
    for (int k = 0; k < 260; k++) run_frame("sat", 8'hFF, 8'h00, 32'h0, 2, 0, 32'h0);
    run_frame("stsat", 8'h03, 8'h00, 32'h0, 6, 0, 32'h0);
    run_frame("clr2",  8'h06, 8'h00, 32'h0, 6, 0, 32'h0);

    // Random frames against the model.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(7, 0))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h03;
        3: op = 8'h04;
        4: op = 8'h06;
        5: op = 8'h07;
        6: op = 8'(($urandom_range(1, 0) == 0) ? 8'h05 : 8'h08 + 8'($urandom_range(200, 0)));
        default: op = 8'h03;
      endcase
      adr = 8'($urandom);
      if (op == 8'h04 && $urandom_range(1, 0) == 0) adr = 8'h5A;
      dl = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(12, 1));
      nb = ($urandom_range(5, 0) == 0) ? int'($urandom_range(5, 1)) : 6;
      run_frame("rnd", op, adr, $urandom, nb, dl, $urandom);
    end

    check_val("mem_stable", 32'(stable_err), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
